// File: rtl/hex_display_scanner.sv
// Multiplexed 7-segment hex scanner: shadow-registered value/dp, prescaled digit
// rotation, leading-zero blanking, and fully registered segment/anode outputs.

module hex_display_seg_dec (
   input  logic [3:0] nib,
   output logic [6:0] seg
);
   // Active-low {g..a} patterns; polarity is handled by the caller.
   always_comb begin
      seg = 7'h7F;
      case (nib)
         4'h0: seg = 7'h40;
         4'h1: seg = 7'h79;
         4'h2: seg = 7'h24;
         4'h3: seg = 7'h30;
         4'h4: seg = 7'h19;
         4'h5: seg = 7'h12;
         4'h6: seg = 7'h02;
         4'h7: seg = 7'h78;
         4'h8: seg = 7'h00;
         4'h9: seg = 7'h10;
         4'hA: seg = 7'h08;
         4'hB: seg = 7'h03;
         4'hC: seg = 7'h46;
         4'hD: seg = 7'h21;
         4'hE: seg = 7'h06;
         4'hF: seg = 7'h0E;
         default: seg = 7'h7F;
      endcase
   end
endmodule

module hex_display_scanner #(
   parameter int NUM_DIGITS     = 4,
   parameter int REFRESH_DIV    = 50000,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1,
   parameter int BLANK_LEADING  = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    load_i,
   input  logic [4*NUM_DIGITS-1:0] value_i,
   input  logic [NUM_DIGITS-1:0]   dp_i,
   input  logic                    enable_i,
   output logic [6:0]              seg_o,
   output logic                    dp_o,
   output logic [NUM_DIGITS-1:0]   an_o,
   output logic                    frame_o
);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int PW = $clog2(REFRESH_DIV);

   localparam logic [6:0]            SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = (AN_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : '0;

   logic [PW-1:0]                  presc;
   logic [IW-1:0]                  idx;
   logic [NUM_DIGITS-1:0][3:0]     shadow;
   logic [NUM_DIGITS-1:0]          shadow_dp;
   logic [NUM_DIGITS-1:0][6:0]     dec_seg;
   logic [NUM_DIGITS-1:0]          blank;
   logic                           zero_run;
   logic [NUM_DIGITS-1:0]          an_hot;
   logic [6:0]                     seg_al;
   logic                           slot_end;

   for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
      hex_display_seg_dec u_dec (.nib(shadow[g]), .seg(dec_seg[g]));
   end

   // Walk from the leftmost digit down; a digit blanks while everything at and
   // above it is still zero. Digit 0 always shows.
   always_comb begin
      zero_run = 1'b1;
      blank    = '0;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         zero_run = zero_run && (shadow[i] == 4'h0);
         if (BLANK_LEADING != 0 && i > 0) blank[i] = zero_run;
      end
   end

   always_comb begin
      an_hot      = '0;
      an_hot[idx] = 1'b1;
      seg_al      = blank[idx] ? 7'h7F : dec_seg[idx];
      slot_end    = (presc == PW'(REFRESH_DIV - 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc     <= '0;
         idx       <= '0;
         shadow    <= '0;
         shadow_dp <= '0;
         seg_o     <= SEG_OFF;
         dp_o      <= DP_OFF;
         an_o      <= AN_OFF;
         frame_o   <= 1'b0;
      end else begin
         if (load_i) begin
            shadow    <= value_i;
            shadow_dp <= dp_i;
         end
         frame_o <= 1'b0;
         if (enable_i) begin
            if (slot_end) begin
               presc <= '0;
               if (idx == IW'(NUM_DIGITS - 1)) begin
                  idx     <= '0;
                  frame_o <= 1'b1;
               end else begin
                  idx <= idx + IW'(1);
               end
            end else begin
               presc <= presc + PW'(1);
            end
            // Outputs reflect the state held before this edge, so anode and
            // segments move together one edge after the index changes.
            seg_o <= (SEG_ACTIVE_LOW != 0) ? seg_al : ~seg_al;
            dp_o  <= (SEG_ACTIVE_LOW != 0) ? ~shadow_dp[idx] : shadow_dp[idx];
            an_o  <= (AN_ACTIVE_LOW != 0) ? ~an_hot : an_hot;
         end else begin
            seg_o <= SEG_OFF;
            dp_o  <= DP_OFF;
            an_o  <= AN_OFF;
         end
      end
   end
endmodule

// File: tb/tb_hex_display_scanner.sv
// Scoreboard bench: stimulus pushes hand-tabulated per-edge expectations, a
// monitor pops and compares them after every clock edge.

module tb_hex_display_scanner;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        load_i = 1'b0;
   logic [15:0] value_i = '0;
   logic [3:0]  dp_i = '0;
   logic        enable_i = 1'b1;
   logic [6:0]  seg_o, seg_nb;
   logic        dp_o, dp_nb;
   logic [3:0]  an_o, an_nb;
   logic        frame_o, frame_nb;

   always #5 clk = ~clk;

   hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
      .clk(clk), .rst(rst), .load_i(load_i), .value_i(value_i), .dp_i(dp_i),
      .enable_i(enable_i), .seg_o(seg_o), .dp_o(dp_o), .an_o(an_o), .frame_o(frame_o));

   hex_display_scanner #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_LEADING(0)) dut_nb (
      .clk(clk), .rst(rst), .load_i(load_i), .value_i(value_i), .dp_i(dp_i),
      .enable_i(enable_i), .seg_o(seg_nb), .dp_o(dp_nb), .an_o(an_nb), .frame_o(frame_nb));

   // Vectors: 0 = reset contents, 1 = 12AF, 2 = 0050, 3 = 0C07.
   logic [15:0] VEC_VAL [0:3] = '{16'h0000, 16'h12AF, 16'h0050, 16'h0C07};
   logic [3:0]  VEC_DP  [0:3] = '{4'b0000, 4'b0100, 4'b0000, 4'b1001};
   // Expected active-low segments per [vector][digit], with and without blanking.
   logic [6:0]  SEG_BL  [0:3][0:3] = '{
      '{7'h40, 7'h7F, 7'h7F, 7'h7F},
      '{7'h0E, 7'h08, 7'h24, 7'h79},
      '{7'h40, 7'h12, 7'h7F, 7'h7F},
      '{7'h78, 7'h40, 7'h46, 7'h7F}};
   logic [6:0]  SEG_NB  [0:3][0:3] = '{
      '{7'h40, 7'h40, 7'h40, 7'h40},
      '{7'h0E, 7'h08, 7'h24, 7'h79},
      '{7'h40, 7'h12, 7'h40, 7'h40},
      '{7'h78, 7'h40, 7'h46, 7'h40}};
   logic [3:0]  AN_TAB  [0:3] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   typedef struct {
      logic [6:0] seg;
      logic       dp;
      logic [3:0] an;
      logic       frame;
      logic [6:0] seg_nb;
      int         edge_no;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   en_edges = 0;
   int   cur_vec = 0;
   int   edge_no = 0;

   task automatic chk(input string name, input int id, input logic [7:0] act,
                      input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s edge %0d: got %h expected %h", name, id, act, exp);
      end
   endtask

   // Called at a negedge: drive inputs, push expectation for the next edge,
   // then wait for the following negedge.
   task automatic step(input logic en, input logic ld, input int vec);
      exp_t e;
      int   d;
      enable_i = en;
      load_i   = ld;
      if (ld) begin
         value_i = VEC_VAL[vec];
         dp_i    = VEC_DP[vec];
      end
      edge_no++;
      e.edge_no = edge_no;
      if (en) begin
         d        = (en_edges / 4) % 4;
         e.seg    = SEG_BL[cur_vec][d];
         e.seg_nb = SEG_NB[cur_vec][d];
         e.dp     = ~VEC_DP[cur_vec][d];
         e.an     = AN_TAB[d];
         e.frame  = (en_edges % 16) == 15;
         en_edges++;
      end else begin
         e.seg    = 7'h7F;
         e.seg_nb = 7'h7F;
         e.dp     = 1'b1;
         e.an     = 4'b1111;
         e.frame  = 1'b0;
      end
      q.push_back(e);
      if (ld) cur_vec = vec;
      @(negedge clk);
   endtask

   task automatic chk_dark(input string name);
      chk({name, "_seg"}, edge_no, 8'(seg_o), 8'h7F);
      chk({name, "_dp"}, edge_no, 8'(dp_o), 8'h01);
      chk({name, "_an"}, edge_no, 8'(an_o), 8'h0F);
      chk({name, "_frame"}, edge_no, 8'(frame_o), 8'h00);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("seg", e.edge_no, 8'(seg_o), 8'(e.seg));
            chk("dp", e.edge_no, 8'(dp_o), 8'(e.dp));
            chk("an", e.edge_no, 8'(an_o), 8'(e.an));
            chk("frame", e.edge_no, 8'(frame_o), 8'(e.frame));
            chk("seg_noblank", e.edge_no, 8'(seg_nb), 8'(e.seg_nb));
         end
      end
   end

   initial begin : stim
      repeat (2) @(negedge clk);
      chk_dark("reset");
      rst = 1'b0;
      // Reset contents: digit 0 shows 0, upper digits blank.
      step(1, 0, 0);
      step(1, 0, 0);
      // 12AF with dp on digit 2, across two full frames.
      step(1, 1, 1);
      for (int i = 0; i < 36; i++) step(1, 0, 0);
      // 0050: leading-zero blanking versus the non-blanking instance.
      step(1, 1, 2);
      for (int i = 0; i < 20; i++) step(1, 0, 0);
      // Disable mid-slot for 10 edges, then resume.
      while ((en_edges % 4) != 1) step(1, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0);
      for (int i = 0; i < 8; i++) step(1, 0, 0);
      // Load on the same edge as an index advance.
      while ((en_edges % 4) != 3) step(1, 0, 0);
      step(1, 1, 3);
      for (int i = 0; i < 20; i++) step(1, 0, 0);
      // Asynchronous reset between edges while digit 2 is displayed.
      while (((en_edges / 4) % 4) != 2) step(1, 0, 0);
      step(1, 0, 0);
      #2;
      rst = 1'b1;
      #1;
      chk_dark("async_rst");
      repeat (2) @(negedge clk);
      rst      = 1'b0;
      en_edges = 0;
      cur_vec  = 0;
      for (int i = 0; i < 6; i++) step(1, 0, 0);
      @(negedge clk);
      chk("queue_drained", edge_no, 8'(q.size()), 8'h00);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
